snn_inference_ctrl: RTL and testbench

SNN_INFERENCE_CTRL -- requirements
Module: snn_inference_ctrl

---
 rtl/snn_ctrl_pkg.sv | 23 ++
 rtl/snn_inference_ctrl_if.sv | 26 ++
 rtl/snn_spike_encoder.sv | 43 ++++
 rtl/snn_inference_ctrl.sv | 178 +++++++++++++++++
 tb/tb_snn_inference_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the SNN inference controller: default parameter
// values, the controller state encoding and a small state-decode helper.
package snn_ctrl_pkg;

  localparam int DEF_IMAGE_SIZE     = 256;
  localparam int DEF_PIXEL_BITS     = 8;
  localparam int DEF_M              = 8;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SCAN  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } snn_state_e;

  // The controller is busy from the neuron clear until the result arrives.
  function automatic logic state_is_busy(input logic [2:0] s);
    return (s == ST_CLEAR) || (s == ST_SCAN) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/snn_inference_ctrl_if.sv
// Spike event channel from the inference controller to the SNN core.
// Valid/ready handshake; an event is consumed when both are high on a
// rising clock edge.
interface snn_inference_ctrl_if
  import snn_ctrl_pkg::*;
#(
  parameter int M = DEF_M
);

  logic         SPK_VALID;
  logic [M-1:0] SPK_ADDR;
  logic         SPK_READY;

  modport master (
    output SPK_VALID,
    output SPK_ADDR,
    input  SPK_READY
  );

  modport slave (
    input  SPK_VALID,
    input  SPK_ADDR,
    output SPK_READY
  );

endinterface

// File: rtl/snn_spike_encoder.sv
// Spike encoder: compares the current pixel against the latched threshold
// and drives the spike channel. Once an event is offered it stays offered,
// with the same address, until the SNN accepts it; the pixel counter only
// advances when the current pixel has been dealt with.
module snn_spike_encoder
  import snn_ctrl_pkg::*;
#(
  parameter int PIXEL_BITS = DEF_PIXEL_BITS,
  parameter int M          = DEF_M,
  parameter int AW         = 8
)(
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  scan_en,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  input  logic [PIXEL_BITS-1:0] threshold,
  input  logic [AW-1:0]         pixel_idx,
  snn_inference_ctrl_if.master  spk,
  output logic                  advance
);

  logic hit;
  logic pend_q;

  // Zero pixels never spike, even with a zero threshold.
  assign hit = scan_en && (pixel_data != '0) && (pixel_data >= threshold);

  // pend_q keeps the event offered even if the pixel source wobbles while
  // the SNN is back-pressuring.
  assign spk.SPK_VALID = scan_en && (hit || pend_q);
  assign spk.SPK_ADDR  = spk.SPK_VALID ? M'(pixel_idx) : '0;
  assign advance       = scan_en && (!spk.SPK_VALID || spk.SPK_READY);

  // Remember an offered event that has not been accepted yet.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= spk.SPK_VALID && !spk.SPK_READY;
    end
  end

endmodule

// File: rtl/snn_inference_ctrl.sv
// SNN inference controller: on a NEW_IMAGE rising edge it clears the SNN
// neuron state, scans every pixel of the image, turns pixels at or above
// the threshold into spike events, then waits for the SNN's winning digit.
// Optional build macro SNN_CTRL_TIMEOUT_EN adds a WAIT-state watchdog that
// reports TIMEOUT and digit all-ones if SNN_DONE never arrives.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a NEW_IMAGE rising edge; previous result visible
// CLEAR | one-cycle SNN_RST pulse, pixel counter and flags cleared
// SCAN  | walking pixel 0..IMAGE_SIZE-1, emitting spike events
// WAIT  | scan complete, waiting for SNN_DONE (or watchdog expiry)
// HOLD  | result latched, DONE high until NEW_IMAGE drops
module snn_inference_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int  IMAGE_SIZE     = DEF_IMAGE_SIZE,
  parameter int  PIXEL_BITS     = DEF_PIXEL_BITS,
  parameter int  M              = DEF_M,
  parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int AW             = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1
)(
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  NEW_IMAGE,
  input  logic [PIXEL_BITS-1:0] THRESHOLD,
  output logic [AW-1:0]         PIXEL_ADDR,
  input  logic [PIXEL_BITS-1:0] PIXEL_DATA,
  snn_inference_ctrl_if.master  spk,
  output logic                  SNN_RST,
  input  logic                  SNN_DONE,
  input  logic [M-1:0]          SNN_DIGIT,
  output logic [M-1:0]          INFERED_DIGIT,
  output logic                  DONE,
  output logic                  BUSY,
  output logic                  TIMEOUT
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_CLEAR = ST_CLEAR;
  localparam logic [2:0] S_SCAN  = ST_SCAN;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_HOLD  = ST_HOLD;

  localparam logic [AW-1:0] LAST_PIXEL = AW'(IMAGE_SIZE - 1);

  logic [2:0]            state;
  logic                  nimg_q;
  logic                  armed_q;
  logic [PIXEL_BITS-1:0] thr_q;
  logic [AW-1:0]         cnt;
  logic                  done_q;
  logic                  timeout_q;
  logic [M-1:0]          digit_q;
  logic                  start;
  logic                  scan_en;
  logic                  advance;
  logic                  wait_tc;

  // armed_q stays low for the first cycle after reset so that a NEW_IMAGE
  // level already high at release is not mistaken for a rising edge.
  assign start   = (state == S_IDLE) && NEW_IMAGE && !nimg_q && armed_q;
  assign scan_en = (state == S_SCAN);

  assign PIXEL_ADDR    = cnt;
  assign SNN_RST       = (state == S_CLEAR);
  assign BUSY          = state_is_busy(state);
  assign DONE          = done_q;
  assign TIMEOUT       = timeout_q;
  assign INFERED_DIGIT = digit_q;

  // NEW_IMAGE edge detector history.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      nimg_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      nimg_q  <= NEW_IMAGE;
      armed_q <= 1'b1;
    end
  end

`ifdef SNN_CTRL_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WAIT_LOAD = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wait_cnt;

  assign wait_tc = (state == S_WAIT) && (wait_cnt == '0);

  // WAIT dwell timer: reloaded outside WAIT, counts down to terminal count.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state != S_WAIT) begin
      wait_cnt <= WAIT_LOAD;
    end else if (wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end
`else
  assign wait_tc = 1'b0;
`endif

  // Main sequencing FSM, pixel counter and result registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      thr_q     <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      digit_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLEAR;
            thr_q     <= THRESHOLD;
            cnt       <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          cnt   <= '0;
          state <= S_SCAN;
        end
        S_SCAN: begin
          // The counter parks on the last pixel rather than wrapping.
          if (advance) begin
            if (cnt == LAST_PIXEL) begin
              state <= S_WAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (SNN_DONE) begin
            digit_q <= SNN_DIGIT;
            done_q  <= 1'b1;
            state   <= S_HOLD;
          end else if (wait_tc) begin
            digit_q   <= '1;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!NEW_IMAGE) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  snn_spike_encoder #(
    .PIXEL_BITS (PIXEL_BITS),
    .M          (M),
    .AW         (AW)
  ) u_encoder (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .scan_en    (scan_en),
    .pixel_data (PIXEL_DATA),
    .threshold  (thr_q),
    .pixel_idx  (cnt),
    .spk        (spk),
    .advance    (advance)
  );

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Self-checking bench for snn_inference_ctrl with a pixel-level reference
// model: expected spikes come from the threshold rule applied to the image
// array, and expected timing from walking the image one pixel per accepted
// or skipped cycle.
module tb_snn_inference_ctrl;

  localparam int IMAGE_SIZE     = 256;
  localparam int PIXEL_BITS     = 8;
  localparam int M              = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int AW             = 8;

  logic                  ACLK      = 1'b0;
  logic                  ARESETN   = 1'b0;
  logic                  NEW_IMAGE = 1'b0;
  logic [PIXEL_BITS-1:0] THRESHOLD = '0;
  logic [AW-1:0]         PIXEL_ADDR;
  logic [PIXEL_BITS-1:0] PIXEL_DATA;
  logic                  SNN_RST;
  logic                  SNN_DONE  = 1'b0;
  logic [M-1:0]          SNN_DIGIT = '0;
  logic [M-1:0]          INFERED_DIGIT;
  logic                  DONE;
  logic                  BUSY;
  logic                  TIMEOUT;

  logic [PIXEL_BITS-1:0] img [IMAGE_SIZE];
  logic [M-1:0]          ev_q [$];
  int                    n_pass = 0;
  int                    n_total = 0;
  int                    rst_pulses = 0;

  snn_inference_ctrl_if #(.M(M)) spk_if ();

  snn_inference_ctrl #(
    .IMAGE_SIZE     (IMAGE_SIZE),
    .PIXEL_BITS     (PIXEL_BITS),
    .M              (M),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .NEW_IMAGE     (NEW_IMAGE),
    .THRESHOLD     (THRESHOLD),
    .PIXEL_ADDR    (PIXEL_ADDR),
    .PIXEL_DATA    (PIXEL_DATA),
    .spk           (spk_if.master),
    .SNN_RST       (SNN_RST),
    .SNN_DONE      (SNN_DONE),
    .SNN_DIGIT     (SNN_DIGIT),
    .INFERED_DIGIT (INFERED_DIGIT),
    .DONE          (DONE),
    .BUSY          (BUSY),
    .TIMEOUT       (TIMEOUT)
  );

  assign PIXEL_DATA = img[PIXEL_ADDR];

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (SNN_RST) rst_pulses++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Starts an image and walks the scan with the reference model; returns in
  // the first WAIT cycle. ready_mode: 0 always ready, 1 random, 2 four-low.
  task automatic run_image(input int ready_mode, input bit wiggle,
                           output int vcyc, output int ticks);
    logic [M-1:0]          exp_q [$];
    logic [PIXEL_BITS-1:0] thr;
    int  mpos, stall_run, rst0;
    bit  expv, rdy, ok;
    thr = THRESHOLD;
    exp_q = {};
    ev_q = {};
    for (int i = 0; i < IMAGE_SIZE; i++)
      if (img[i] != 0 && img[i] >= thr) exp_q.push_back(M'(i));
    rst0 = rst_pulses;
    spk_if.SPK_READY = 1'b0;
    NEW_IMAGE = 1'b1;
    tick();
    n_total++;
    if ({SNN_RST, BUSY, DONE, TIMEOUT} !== 4'b1100)
      $display("FAIL clear_cycle: got rst/busy/done/to=%b want 1100", {SNN_RST, BUSY, DONE, TIMEOUT});
    else n_pass++;
    THRESHOLD = PIXEL_BITS'($urandom);
    tick();
    mpos = 0; stall_run = 0; vcyc = 0; ticks = 1;
    while (mpos < IMAGE_SIZE) begin
      expv = (img[mpos] != 0) && (img[mpos] >= thr);
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (stall_run >= 4);
      endcase
      spk_if.SPK_READY = rdy;
      if (wiggle) NEW_IMAGE = 1'($urandom_range(0, 1));
      #1;
      n_total++;
      if ({spk_if.SPK_VALID, (spk_if.SPK_VALID ? spk_if.SPK_ADDR : 8'h00), PIXEL_ADDR, BUSY, DONE}
          !== {expv, (expv ? M'(mpos) : 8'h00), AW'(mpos), 1'b1, 1'b0})
        $display("FAIL scan_cycle px%0d: got v=%b a=%0d pa=%0d busy=%b done=%b want v=%b a=%0d pa=%0d busy=1 done=0",
                 mpos, spk_if.SPK_VALID, spk_if.SPK_ADDR, PIXEL_ADDR, BUSY, DONE, expv, mpos, mpos);
      else n_pass++;
      if (spk_if.SPK_VALID) vcyc++;
      if (spk_if.SPK_VALID && rdy) ev_q.push_back(spk_if.SPK_ADDR);
      if (!expv || rdy) begin
        mpos++;
        stall_run = 0;
      end else begin
        stall_run++;
      end
      tick();
      ticks++;
    end
    spk_if.SPK_READY = 1'b0;
    n_total++;
    if ({BUSY, spk_if.SPK_VALID} !== 2'b10)
      $display("FAIL wait_entry: got busy/valid=%b want 10", {BUSY, spk_if.SPK_VALID});
    else n_pass++;
    ok = (ev_q.size() == exp_q.size());
    if (ok) foreach (exp_q[i]) if (ev_q[i] !== exp_q[i]) ok = 1'b0;
    n_total++;
    if (!ok) $display("FAIL spike_events: got %0d events want %0d (order/address compared)", ev_q.size(), exp_q.size());
    else n_pass++;
    n_total++;
    if (rst_pulses - rst0 !== 1)
      $display("FAIL snn_rst_pulses: got %0d want 1", rst_pulses - rst0);
    else n_pass++;
  endtask

  // From the first WAIT cycle: dwell, deliver a result, release NEW_IMAGE.
  task automatic finish_image(input int dwell, input logic [M-1:0] d);
    SNN_DONE = 1'b0;
    for (int k = 0; k < dwell; k++) begin
      NEW_IMAGE = 1'($urandom_range(0, 1));
      tick();
    end
    n_total++;
    if ({TIMEOUT, DONE, BUSY} !== 3'b001)
      $display("FAIL wait_dwell: got to/done/busy=%b want 001", {TIMEOUT, DONE, BUSY});
    else n_pass++;
    NEW_IMAGE = 1'b1;
    SNN_DONE = 1'b1;
    SNN_DIGIT = d;
    tick();
    SNN_DONE = 1'b0;
    SNN_DIGIT = M'($urandom);
    n_total++;
    if ({DONE, BUSY, TIMEOUT, INFERED_DIGIT} !== {3'b100, d})
      $display("FAIL result: got done/busy/to=%b digit=%0d want 100 digit=%0d", {DONE, BUSY, TIMEOUT}, INFERED_DIGIT, d);
    else n_pass++;
    tick();
    NEW_IMAGE = 1'b0;
    tick();
    tick();
    n_total++;
    if ({DONE, BUSY, INFERED_DIGIT} !== {2'b10, d})
      $display("FAIL idle_after_hold: got done/busy=%b digit=%0d want 10 digit=%0d", {DONE, BUSY}, INFERED_DIGIT, d);
    else n_pass++;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    NEW_IMAGE = 1'b1;
    spk_if.SPK_READY = 1'b0;
    foreach (img[i]) img[i] = '0;
    repeat (3) @(posedge ACLK);
    #1;
    n_total++;
    if ({spk_if.SPK_VALID, spk_if.SPK_ADDR, SNN_RST, INFERED_DIGIT, DONE, BUSY, TIMEOUT, PIXEL_ADDR} !== '0)
      $display("FAIL reset_values: got %h want 0",
               {spk_if.SPK_VALID, spk_if.SPK_ADDR, SNN_RST, INFERED_DIGIT, DONE, BUSY, TIMEOUT, PIXEL_ADDR});
    else n_pass++;
    ARESETN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_total++;
      if ({BUSY, SNN_RST} !== 2'b00)
        $display("FAIL high_at_release: got busy/rst=%b want 00", {BUSY, SNN_RST});
      else n_pass++;
    end
    NEW_IMAGE = 1'b0;
    tick();
  endtask

  task automatic test_all_zero();
    int vc, tk;
    logic [M-1:0] d;
    foreach (img[i]) img[i] = '0;
    THRESHOLD = PIXEL_BITS'($urandom);
    d = M'($urandom);
    SNN_DIGIT = d;
    SNN_DONE = 1'b1;
    run_image(0, 0, vc, tk);
    n_total++;
    if (tk !== IMAGE_SIZE + 1)
      $display("FAIL scan_latency: got %0d cycles clear->wait want %0d", tk, IMAGE_SIZE + 1);
    else n_pass++;
    n_total++;
    if (vc !== 0) $display("FAIL zero_image_valid: got %0d valid cycles want 0", vc);
    else n_pass++;
    tick();
    SNN_DONE = 1'b0;
    n_total++;
    if ({DONE, BUSY, INFERED_DIGIT} !== {2'b10, d})
      $display("FAIL done_in_wait: got done/busy=%b digit=%0d want 10 digit=%0d", {DONE, BUSY}, INFERED_DIGIT, d);
    else n_pass++;
    NEW_IMAGE = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_threshold();
    int vc, tk;
    foreach (img[i]) img[i] = '0;
    img[5] = 8'd200;
    img[17] = 8'd128;
    img[18] = 8'd127;
    THRESHOLD = 8'd128;
    run_image(0, 0, vc, tk);
    n_total++;
    if (vc !== 2) $display("FAIL threshold_events: got %0d valid cycles want 2", vc);
    else n_pass++;
    finish_image(3, 8'd7);
  endtask

  task automatic test_backpressure();
    int vc, tk;
    foreach (img[i]) img[i] = '0;
    img[3] = 8'd255;
    THRESHOLD = PIXEL_BITS'($urandom_range(1, 255));
    run_image(2, 0, vc, tk);
    n_total++;
    if (vc !== 5) $display("FAIL stall_valid_cycles: got %0d want 5", vc);
    else n_pass++;
    n_total++;
    if (tk !== IMAGE_SIZE + 5)
      $display("FAIL stall_latency: got %0d cycles clear->wait want %0d", tk, IMAGE_SIZE + 5);
    else n_pass++;
    finish_image($urandom_range(0, 10), M'($urandom));
  endtask

  task automatic test_random(input int n);
    int vc, tk;
    for (int r = 0; r < n; r++) begin
      foreach (img[i]) img[i] = ($urandom_range(0, 3) == 0) ? '0 : PIXEL_BITS'($urandom);
      THRESHOLD = PIXEL_BITS'($urandom);
      run_image(1, 1, vc, tk);
      finish_image($urandom_range(0, 10), M'($urandom));
    end
  endtask

  task automatic test_timeout();
    int vc, tk;
    foreach (img[i]) img[i] = PIXEL_BITS'($urandom);
    THRESHOLD = PIXEL_BITS'($urandom);
    run_image(1, 0, vc, tk);
    SNN_DONE = 1'b0;
`ifdef SNN_CTRL_TIMEOUT_EN
    for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
      tick();
      n_total++;
      if ({TIMEOUT, DONE, BUSY} !== 3'b001)
        $display("FAIL timeout_early: cycle %0d got to/done/busy=%b want 001", k, {TIMEOUT, DONE, BUSY});
      else n_pass++;
    end
    tick();
    n_total++;
    if ({TIMEOUT, DONE, BUSY, INFERED_DIGIT} !== {3'b110, 8'hFF})
      $display("FAIL timeout_fire: got to/done/busy=%b digit=%h want 110 digit=ff", {TIMEOUT, DONE, BUSY}, INFERED_DIGIT);
    else n_pass++;
    NEW_IMAGE = 1'b0;
    tick();
    tick();
`else
    repeat (40) tick();
    n_total++;
    if ({TIMEOUT, DONE, BUSY} !== 3'b001)
      $display("FAIL wait_forever: got to/done/busy=%b want 001", {TIMEOUT, DONE, BUSY});
    else n_pass++;
    finish_image(0, M'($urandom));
`endif
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    foreach (img[i]) img[i] = '0;
    img[10] = 8'd255;
    THRESHOLD = 8'd1;
    spk_if.SPK_READY = 1'b0;
    NEW_IMAGE = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (spk_if.SPK_VALID) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL midscan_valid: got no SPK_VALID within 40 cycles want valid at pixel 10");
    else n_pass++;
    ARESETN = 1'b0;
    #1;
    n_total++;
    if ({spk_if.SPK_VALID, spk_if.SPK_ADDR, SNN_RST, INFERED_DIGIT, DONE, BUSY, TIMEOUT, PIXEL_ADDR} !== '0)
      $display("FAIL midscan_reset: got %h want 0",
               {spk_if.SPK_VALID, spk_if.SPK_ADDR, SNN_RST, INFERED_DIGIT, DONE, BUSY, TIMEOUT, PIXEL_ADDR});
    else n_pass++;
    tick();
    tick();
    ARESETN = 1'b1;
    spk_if.SPK_READY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_total++;
      if ({BUSY, SNN_RST, spk_if.SPK_VALID} !== 3'b000)
        $display("FAIL no_restart: got busy/rst/valid=%b want 000", {BUSY, SNN_RST, spk_if.SPK_VALID});
      else n_pass++;
    end
    NEW_IMAGE = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_threshold();
    test_backpressure();
    test_random(5);
    test_timeout();
    test_random(1);
    test_reset_mid_scan();
    test_random(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
